mem_bus_responder: RTL and testbench



---
 rtl/mem_bus_responder.sv | 146 ++++++++++++++
 tb/tb_mem_bus_responder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_responder.sv
// Main-memory responder on the snooping bus: fixed-latency BusRd fills with write-buffer
// forwarding, flush abort, and a circular write buffer drained into the backing array.
module mem_bus_responder #(
    parameter int unsigned ADDRESSWIDTH = 16,
    parameter int unsigned DATABUSWIDTH = 32,
    parameter int unsigned RDLATENCY    = 3,
    parameter int unsigned WBDEPTH      = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    bus_rd,
    input  logic                    bus_wb,
    input  logic [ADDRESSWIDTH-1:0] bus_addr,
    input  logic [DATABUSWIDTH-1:0] bus_wdata,
    input  logic                    bus_flush,
    output logic [DATABUSWIDTH-1:0] bus_rdata,
    output logic                    bus_rvalid,
    output logic                    bus_busy,
    output logic                    wb_full
);
    localparam int unsigned BlkW  = ADDRESSWIDTH - 2;
    localparam int unsigned PtrW  = $clog2(WBDEPTH);
    localparam int unsigned CntW  = PtrW + 1;
    localparam int unsigned Words = 2 ** BlkW;

    typedef enum logic [1:0] {StIdle, StRdWait, StResp} state_e;

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [BlkW-1:0]         raddr_q, raddr_d;
    logic [DATABUSWIDTH-1:0] rdata_q, rdata_d;
    logic                    rvalid_q, rvalid_d;
    logic                    busy_q, busy_d;
    logic                    full_q, full_d;
    logic [PtrW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]         wb_cnt_q, wb_cnt_d;

    logic [BlkW-1:0]         wb_addr_q [WBDEPTH];
    logic [DATABUSWIDTH-1:0] wb_data_q [WBDEPTH];
    logic [DATABUSWIDTH-1:0] mem_q     [Words];

    logic                    accept, push, pop, fwd_hit;
    logic [DATABUSWIDTH-1:0] fwd_data;
    logic [PtrW-1:0]         idx;
    logic                    unused_addr_lo;

    assign unused_addr_lo = ^bus_addr[1:0];

    assign accept = (state_q == StIdle) && bus_rd && !bus_flush;
    assign push   = bus_wb && (wb_cnt_q != CntW'(WBDEPTH));
    // Drain only when the array read port is not needed by a new fill.
    assign pop    = (state_q == StIdle) && !accept && (wb_cnt_q != '0);

    // Scan oldest to youngest so the youngest matching entry wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int unsigned i = 0; i < WBDEPTH; i++) begin
            idx = rd_ptr_q + PtrW'(i);
            if ((CntW'(i) < wb_cnt_q) && (wb_addr_q[idx] == raddr_q)) begin
                fwd_hit  = 1'b1;
                fwd_data = wb_data_q[idx];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        raddr_d  = raddr_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    raddr_d = bus_addr[ADDRESSWIDTH-1:2];
                    cnt_d   = 4'(RDLATENCY - 1);
                    state_d = StRdWait;
                end
            end
            StRdWait: begin
                if (bus_flush) begin
                    state_d = StIdle;
                end else if (cnt_q == '0) begin
                    state_d  = StResp;
                    rvalid_d = 1'b1;
                    rdata_d  = fwd_hit ? fwd_data : mem_q[raddr_q];
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        busy_d   = (state_d != StIdle);
        wr_ptr_d = wr_ptr_q + PtrW'(push);
        rd_ptr_d = rd_ptr_q + PtrW'(pop);
        wb_cnt_d = wb_cnt_q + CntW'(push) - CntW'(pop);
        full_d   = (wb_cnt_d == CntW'(WBDEPTH));
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            raddr_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            busy_q   <= 1'b0;
            full_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            wb_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            raddr_q  <= raddr_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            busy_q   <= busy_d;
            full_q   <= full_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            wb_cnt_q <= wb_cnt_d;
        end
    end

    // Storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clock) begin
        if (push) begin
            wb_addr_q[wr_ptr_q] <= bus_addr[ADDRESSWIDTH-1:2];
            wb_data_q[wr_ptr_q] <= bus_wdata;
        end
        if (pop && reset) begin
            mem_q[wb_addr_q[rd_ptr_q]] <= wb_data_q[rd_ptr_q];
        end
    end

    assign bus_rdata  = rdata_q;
    assign bus_rvalid = rvalid_q;
    assign bus_busy   = busy_q;
    assign wb_full    = full_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed self-checking bench for mem_bus_responder (default parameters, RDLATENCY=3).
module tb_mem_bus_responder;
    logic        clock, reset, bus_rd, bus_wb, bus_flush;
    logic [15:0] bus_addr;
    logic [31:0] bus_wdata, bus_rdata;
    logic        bus_rvalid, bus_busy, wb_full;

    int n_tests = 0;
    int n_fail  = 0;

    mem_bus_responder dut (
        .clock     (clock),
        .reset     (reset),
        .bus_rd    (bus_rd),
        .bus_wb    (bus_wb),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_flush (bus_flush),
        .bus_rdata (bus_rdata),
        .bus_rvalid(bus_rvalid),
        .bus_busy  (bus_busy),
        .wb_full   (wb_full)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Called right after the accept edge; returns the cycle count to the rvalid strobe.
    task automatic wait_fill(output logic [31:0] data, output int lat);
        lat  = 0;
        data = '0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (bus_rvalid) begin
                lat  = i;
                data = bus_rdata;
                break;
            end
        end
    endtask

    task automatic read_check(input string tag, input logic [15:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        int          lat;
        bus_rd   = 1'b1;
        bus_addr = addr;
        step();
        bus_rd = 1'b0;
        wait_fill(d, lat);
        check_eq({tag, "_data"}, d, exp);
        check_eq({tag, "_lat"}, lat, 3);
        step();
    endtask

    task automatic write_drain(input logic [15:0] addr, input logic [31:0] data);
        bus_wb    = 1'b1;
        bus_addr  = addr;
        bus_wdata = data;
        step();
        bus_wb = 1'b0;
        step();
    endtask

    initial begin
        logic [31:0] d;
        int          lat;
        int          seen;
        int          w;

        reset = 1'b0; bus_rd = 1'b0; bus_wb = 1'b0; bus_flush = 1'b0;
        bus_addr = '0; bus_wdata = '0;
        step();
        step();
        check_eq("rst_busy", bus_busy, 0);
        check_eq("rst_rvalid", bus_rvalid, 0);
        check_eq("rst_rdata", bus_rdata, 0);
        check_eq("rst_full", wb_full, 0);
        reset = 1'b1;
        step();

        // Reset one cycle after an accepted read discards the fill.
        bus_rd = 1'b1; bus_addr = 16'h1234;
        step();
        bus_rd = 1'b0;
        check_eq("midfill_busy_accept", bus_busy, 1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        check_eq("midfill_busy", bus_busy, 0);
        check_eq("midfill_full", wb_full, 0);
        check_eq("midfill_rvalid", bus_rvalid, 0);
        seen = 0;
        repeat (6) begin
            step();
            if (bus_rvalid) seen++;
        end
        check_eq("midfill_no_rvalid", seen, 0);

        write_drain(16'h1234, 32'hCAFEF00D);
        write_drain(16'h2010, 32'h0000EEEE);

        // Basic fill timing.
        bus_rd = 1'b1; bus_addr = 16'h1234;
        step();
        bus_rd = 1'b0;
        check_eq("fill_t0_busy", bus_busy, 1);
        check_eq("fill_t0_rvalid", bus_rvalid, 0);
        step();
        check_eq("fill_t1_busy", bus_busy, 1);
        check_eq("fill_t1_rvalid", bus_rvalid, 0);
        step();
        check_eq("fill_t2_rvalid", bus_rvalid, 0);
        step();
        check_eq("fill_t3_rvalid", bus_rvalid, 1);
        check_eq("fill_t3_rdata", bus_rdata, 32'hCAFEF00D);
        check_eq("fill_t3_busy", bus_busy, 1);
        step();
        check_eq("fill_t4_rvalid", bus_rvalid, 0);
        check_eq("fill_t4_busy", bus_busy, 0);
        check_eq("fill_t4_rdata_hold", bus_rdata, 32'hCAFEF00D);

        // Writeback and read of the same block on the same edge.
        bus_wb = 1'b1; bus_rd = 1'b1; bus_addr = 16'h0400; bus_wdata = 32'h11111111;
        step();
        bus_wb = 1'b0; bus_rd = 1'b0;
        wait_fill(d, lat);
        check_eq("fwd_data", d, 32'h11111111);
        check_eq("fwd_lat", lat, 3);
        step(); step(); step();
        read_check("fwd_array", 16'h0400, 32'h11111111);

        // Flush at T0+2 aborts; the next read is accepted at T0+3.
        bus_rd = 1'b1; bus_addr = 16'h1234;
        step();
        bus_rd = 1'b0;
        step();
        check_eq("flush_t1_rvalid", bus_rvalid, 0);
        bus_flush = 1'b1;
        step();
        bus_flush = 1'b0;
        check_eq("flush_t2_busy", bus_busy, 0);
        check_eq("flush_t2_rvalid", bus_rvalid, 0);
        bus_rd = 1'b1; bus_addr = 16'h0400;
        step();
        bus_rd = 1'b0;
        check_eq("flush_t3_accept", bus_busy, 1);
        wait_fill(d, lat);
        check_eq("flush_next_data", d, 32'h11111111);
        check_eq("flush_next_lat", lat, 3);
        step();

        // Back-to-back reads block draining while the buffer fills.
        bus_rd = 1'b1; bus_addr = 16'h1234;
        step();
        for (int k = 0; k < 5; k++) begin
            bus_wb = 1'b1; bus_addr = 16'h2000 + 16'(4 * k); bus_wdata = 32'hD0 + 32'(k);
            step();
            check_eq($sformatf("full_push%0d", k), wb_full, (k >= 3) ? 1 : 0);
        end
        bus_wb = 1'b0; bus_rd = 1'b0;
        w = 0;
        while (bus_busy && w < 20) begin
            step();
            w++;
        end
        check_eq("full_idle_reached", bus_busy, 0);
        check_eq("full_before_drain", wb_full, 1);
        step();
        check_eq("full_after_drain1", wb_full, 0);
        step(); step(); step();
        for (int k = 0; k < 4; k++) begin
            read_check($sformatf("drain%0d", k), 16'h2000 + 16'(4 * k), 32'hD0 + 32'(k));
        end
        read_check("dropped_push", 16'h2010, 32'h0000EEEE);

        for (int j = 0; j < 6; j++) begin
            write_drain(16'h3000 + 16'(4 * j), 32'h300 + 32'(j));
            check_eq($sformatf("wrap_full%0d", j), wb_full, 0);
        end
        read_check("wrap_first", 16'h3000, 32'h300);
        read_check("wrap_last", 16'h3014, 32'h305);

        // Duplicate block: youngest entry wins for forwarding and after drain.
        bus_wb = 1'b1; bus_addr = 16'h0800; bus_wdata = 32'hA;
        step();
        bus_wdata = 32'hB; bus_rd = 1'b1;
        step();
        bus_wb = 1'b0; bus_rd = 1'b0;
        wait_fill(d, lat);
        check_eq("dup_fwd_data", d, 32'hB);
        check_eq("dup_fwd_lat", lat, 3);
        step(); step(); step();
        read_check("dup_array", 16'h0800, 32'hB);

        // Reset with a full buffer discards all entries.
        bus_rd = 1'b1; bus_addr = 16'h1234;
        step();
        for (int k = 0; k < 4; k++) begin
            bus_wb = 1'b1; bus_addr = 16'h2000 + 16'(4 * k); bus_wdata = 32'hBAD;
            step();
        end
        bus_wb = 1'b0; bus_rd = 1'b0;
        check_eq("rst_full_pre", wb_full, 1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        check_eq("rst_full_post", wb_full, 0);
        check_eq("rst_busy_post", bus_busy, 0);
        check_eq("rst_rvalid_post", bus_rvalid, 0);
        step(); step();
        read_check("rst_discard", 16'h2000, 32'hD0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

endmodule
